// File: rtl/ysyx_23060136_ifu_fetch_pkg.sv
// Shared types for the IFU fetch stage: FSM state encoding, response codes
// and the fetch-entry record handed to IFU2.
package ysyx_23060136_ifu_fetch_pkg;

   localparam int ysyx_23060136_BITS_W = 32;
   localparam int ysyx_23060136_INST_W = 32;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_KILL,
      DATA,
      DROP
   } fetch_state_e;

   typedef struct packed {
      logic [ysyx_23060136_BITS_W-1:0] pc;
      logic [ysyx_23060136_INST_W-1:0] inst;
      logic                            fault;
   } fetch_entry_t;

   function automatic fetch_entry_t make_entry(
      input logic [ysyx_23060136_BITS_W-1:0] pc,
      input logic [ysyx_23060136_INST_W-1:0] inst,
      input logic [1:0]                      resp
   );
      fetch_entry_t e;
      e.pc    = pc;
      e.inst  = inst;
      e.fault = (resp != RESP_OKAY);
      return e;
   endfunction

endpackage

// File: rtl/ysyx_23060136_ifu_fetch_buf.sv
// One-entry output buffer between the fetch FSM and IFU2; flush has priority
// over a same-cycle write, and a write wins over a same-cycle drain.
module ysyx_23060136_IFU_FETCH_BUF
   import ysyx_23060136_ifu_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_wr,
   input  fetch_entry_t i_entry,
   input  logic         i_flush,
   input  logic         i_ready,
   output logic         o_valid,
   output fetch_entry_t o_entry
);

   logic         r_valid;
   fetch_entry_t r_entry;

   // NOTE: the payload is reset as well because IFU2_pc/IFU2_inst must read zero during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_entry <= '0;
      end else begin
         if (i_flush)
            r_valid <= 1'b0;
         else if (i_wr)
            r_valid <= 1'b1;
         else if (r_valid && i_ready)
            r_valid <= 1'b0;

         if (i_wr && !i_flush)
            r_entry <= i_entry;
      end
   end

   assign o_valid = r_valid;
   assign o_entry = r_entry;

endmodule

// File: rtl/ysyx_23060136_ifu_fetch.sv
// IFU fetch stage: issues one instruction-memory read at a time and hands the
// result to IFU2. Optional perf counters under YSYX_23060136_IFU_PERF_EN.
module ysyx_23060136_ifu_fetch
   import ysyx_23060136_ifu_fetch_pkg::*;
#(
   parameter int INST_W = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ysyx_23060136_BITS_W-1:0] IFU1_pc,
   input  logic                            BRANCH_PCSrc,
   output logic                            IFU_stall,
   output logic                            ifu_arvalid,
   output logic [ysyx_23060136_BITS_W-1:0] ifu_araddr,
   input  logic                            ifu_arready,
   input  logic                            ifu_rvalid,
   input  logic [INST_W-1:0]               ifu_rdata,
   input  logic [1:0]                      ifu_rresp,
   output logic                            ifu_rready,
   output logic                            IFU2_valid,
   input  logic                            IFU2_ready,
   output logic [ysyx_23060136_BITS_W-1:0] IFU2_pc,
   output logic [INST_W-1:0]               IFU2_inst,
   output logic                            IFU2_fault
`ifdef YSYX_23060136_IFU_PERF_EN
   ,
   output logic [63:0]                     perf_fetch_cnt,
   output logic [63:0]                     perf_stall_cnt
`endif
);

   fetch_state_e                    r_state;
   fetch_state_e                    w_state_nxt;
   logic [ysyx_23060136_BITS_W-1:0] r_araddr;
   logic                            w_ld_addr;
   logic                            w_buf_wr;
   logic                            w_buf_free;
   logic                            w_rready;
   fetch_entry_t                    w_wr_entry;
   fetch_entry_t                    w_out_entry;

   // Draining counts as free: the entry leaves at the same edge a new one may arrive.
   assign w_buf_free = !IFU2_valid || IFU2_ready;
   assign w_rready   = ((r_state == DATA) && w_buf_free) || (r_state == DROP);
   assign w_wr_entry = make_entry(r_araddr, ifu_rdata, ifu_rresp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_araddr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld_addr)
            r_araddr <= IFU1_pc;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_addr   = 1'b0;
      w_buf_wr    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!BRANCH_PCSrc && w_buf_free) begin
               w_state_nxt = ADDR;
               w_ld_addr   = 1'b1;
            end
         end
         ADDR: begin
            if (ifu_arready)
               w_state_nxt = BRANCH_PCSrc ? DROP : DATA;
            else if (BRANCH_PCSrc)
               w_state_nxt = ADDR_KILL;
         end
         ADDR_KILL: begin
            if (ifu_arready)
               w_state_nxt = DROP;
         end
         DATA: begin
            if (ifu_rvalid && w_rready) begin
               w_state_nxt = IDLE;
               w_buf_wr    = !BRANCH_PCSrc;
            end else if (BRANCH_PCSrc) begin
               w_state_nxt = DROP;
            end
         end
         DROP: begin
            if (ifu_rvalid)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   ysyx_23060136_IFU_FETCH_BUF u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_buf_wr),
      .i_entry (w_wr_entry),
      .i_flush (BRANCH_PCSrc),
      .i_ready (IFU2_ready),
      .o_valid (IFU2_valid),
      .o_entry (w_out_entry)
   );

   assign ifu_arvalid = (r_state == ADDR) || (r_state == ADDR_KILL);
   assign ifu_araddr  = r_araddr;
   assign ifu_rready  = w_rready;
   assign IFU2_pc     = w_out_entry.pc;
   assign IFU2_inst   = w_out_entry.inst;
   assign IFU2_fault  = w_out_entry.fault;
   // Reset forces a hold; otherwise release only to load a branch target or on a buffer write.
   assign IFU_stall   = !rst_n || !(BRANCH_PCSrc || w_buf_wr);

`ifdef YSYX_23060136_IFU_PERF_EN
   logic [63:0] r_fetch_cnt;
   logic [63:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_buf_wr)
            r_fetch_cnt <= r_fetch_cnt + 64'd1;
         if (IFU_stall)
            r_stall_cnt <= r_stall_cnt + 64'd1;
      end
   end

   assign perf_fetch_cnt = r_fetch_cnt;
   assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
// Directed bench for ysyx_23060136_ifu_fetch: a table of fetch transactions
// plus hand-written flush, back-pressure and reset sequences.
module tb_ysyx_23060136_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] IFU1_pc;
   logic        BRANCH_PCSrc;
   logic        IFU_stall;
   logic        ifu_arvalid;
   logic [31:0] ifu_araddr;
   logic        ifu_arready;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rready;
   logic        IFU2_valid;
   logic        IFU2_ready;
   logic [31:0] IFU2_pc;
   logic [31:0] IFU2_inst;
   logic        IFU2_fault;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ysyx_23060136_ifu_fetch #(.INST_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .IFU1_pc      (IFU1_pc),
      .BRANCH_PCSrc (BRANCH_PCSrc),
      .IFU_stall    (IFU_stall),
      .ifu_arvalid  (ifu_arvalid),
      .ifu_araddr   (ifu_araddr),
      .ifu_arready  (ifu_arready),
      .ifu_rvalid   (ifu_rvalid),
      .ifu_rdata    (ifu_rdata),
      .ifu_rresp    (ifu_rresp),
      .ifu_rready   (ifu_rready),
      .IFU2_valid   (IFU2_valid),
      .IFU2_ready   (IFU2_ready),
      .IFU2_pc      (IFU2_pc),
      .IFU2_inst    (IFU2_inst),
      .IFU2_fault   (IFU2_fault)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      int          ar_dly;
      int          r_dly;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic        exp_fault;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge, outputs are checked 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Entry: state IDLE, buffer empty or about to drain. Exit: IDLE, buffer holding v, IFU2_ready=0.
   task automatic run_fetch(input vec_t v);
      IFU1_pc = v.pc; IFU2_ready = 1'b1; ifu_arready = 1'b0; ifu_rvalid = 1'b0;
      settle();
      check("idle_arvalid", ifu_arvalid, 0);
      check("idle_stall", IFU_stall, 1);
      tick();
      IFU2_ready = 1'b0;
      for (int i = 0; i < v.ar_dly; i++) begin
         IFU1_pc = v.pc + 32'h40 * (i + 1);
         settle();
         check("wait_arvalid", ifu_arvalid, 1);
         check("wait_araddr", ifu_araddr, v.exp_pc);
         check("wait_stall", IFU_stall, 1);
         tick();
      end
      ifu_arready = 1'b1;
      settle();
      check("addr_arvalid", ifu_arvalid, 1);
      check("addr_araddr", ifu_araddr, v.exp_pc);
      check("addr_buf_empty", IFU2_valid, 0);
      tick();
      ifu_arready = 1'b0;
      for (int i = 0; i < v.r_dly; i++) begin
         settle();
         check("data_wait_rready", ifu_rready, 1);
         check("data_wait_stall", IFU_stall, 1);
         check("data_wait_arvalid", ifu_arvalid, 0);
         tick();
      end
      ifu_rvalid = 1'b1; ifu_rdata = v.rdata; ifu_rresp = v.rresp;
      settle();
      check("data_rready", ifu_rready, 1);
      check("data_stall", IFU_stall, 0);
      check("data_valid_pre", IFU2_valid, 0);
      tick();
      ifu_rvalid = 1'b0; ifu_rdata = 32'h0; ifu_rresp = 2'b00;
      settle();
      check("out_valid", IFU2_valid, 1);
      check("out_pc", IFU2_pc, v.exp_pc);
      check("out_inst", IFU2_inst, v.exp_inst);
      check("out_fault", IFU2_fault, v.exp_fault);
      check("out_stall", IFU_stall, 1);
   endtask

   initial begin
      vecs[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 32'h8000_0000, 32'h0000_0413, 1'b0};
      vecs[1] = '{32'h8000_0004, 32'h0010_0093, 2'b00, 4, 0, 32'h8000_0004, 32'h0010_0093, 1'b0};
      vecs[2] = '{32'h8000_0008, 32'h1234_5678, 2'b10, 0, 2, 32'h8000_0008, 32'h1234_5678, 1'b1};
      vecs[3] = '{32'h8000_000C, 32'hFFFF_FFFF, 2'b11, 1, 1, 32'h8000_000C, 32'hFFFF_FFFF, 1'b1};
      vecs[4] = '{32'h8000_0010, 32'h0000_8067, 2'b01, 2, 3, 32'h8000_0010, 32'h0000_8067, 1'b1};

      rst_n = 1'b0; IFU1_pc = 32'h8000_0000; BRANCH_PCSrc = 1'b0;
      ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = 32'h0; ifu_rresp = 2'b00; IFU2_ready = 1'b1;
      settle();
      check("rst_arvalid", ifu_arvalid, 0);
      check("rst_rready", ifu_rready, 0);
      check("rst_valid", IFU2_valid, 0);
      check("rst_fault", IFU2_fault, 0);
      check("rst_pc", IFU2_pc, 0);
      check("rst_inst", IFU2_inst, 0);
      check("rst_araddr", ifu_araddr, 0);
      check("rst_stall", IFU_stall, 1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      for (int k = 0; k < 5; k++)
         run_fetch(vecs[k]);

      // Back-pressure: full buffer held stable, no new request until IFU2 drains.
      IFU1_pc = 32'h8000_0020;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("bp_valid", IFU2_valid, 1);
         check("bp_pc", IFU2_pc, 32'h8000_0010);
         check("bp_inst", IFU2_inst, 32'h0000_8067);
         check("bp_arvalid", ifu_arvalid, 0);
         check("bp_stall", IFU_stall, 1);
         tick();
      end
      IFU2_ready = 1'b1;
      settle();
      check("drain_valid", IFU2_valid, 1);
      tick();
      IFU2_ready = 1'b0;
      settle();
      check("drain_empty", IFU2_valid, 0);
      check("drain_accept_arvalid", ifu_arvalid, 1);
      check("drain_accept_araddr", ifu_araddr, 32'h8000_0020);

      // Flush while in ADDR: request stays up, its response is dropped.
      BRANCH_PCSrc = 1'b1; IFU1_pc = 32'h8000_0100;
      settle();
      check("kill_stall", IFU_stall, 0);
      tick();
      BRANCH_PCSrc = 1'b0;
      settle();
      check("kill_arvalid", ifu_arvalid, 1);
      check("kill_araddr", ifu_araddr, 32'h8000_0020);
      check("kill_stall_hold", IFU_stall, 1);
      ifu_arready = 1'b1;
      tick();
      ifu_arready = 1'b0; ifu_rvalid = 1'b1; ifu_rdata = 32'hDEAD_BEEF;
      settle();
      check("drop_rready", ifu_rready, 1);
      check("drop_stall", IFU_stall, 1);
      tick();
      ifu_rvalid = 1'b0;
      settle();
      check("drop_no_entry", IFU2_valid, 0);
      tick();
      settle();
      check("retarget_arvalid", ifu_arvalid, 1);
      check("retarget_araddr", ifu_araddr, 32'h8000_0100);

      // Flush in DATA before rvalid: stale response dropped, next fetch from the new target.
      ifu_arready = 1'b1;
      tick();
      ifu_arready = 1'b0; BRANCH_PCSrc = 1'b1; IFU1_pc = 32'h8000_0200;
      settle();
      check("dflush_stall", IFU_stall, 0);
      tick();
      BRANCH_PCSrc = 1'b0;
      settle();
      check("dflush_drop_rready", ifu_rready, 1);
      check("dflush_drop_stall", IFU_stall, 1);
      tick();
      ifu_rvalid = 1'b1; ifu_rdata = 32'hBAD0_BAD0;
      tick();
      ifu_rvalid = 1'b0;
      settle();
      check("dflush_no_entry", IFU2_valid, 0);
      tick();
      settle();
      check("dflush_next_araddr", ifu_araddr, 32'h8000_0200);
      ifu_arready = 1'b1;
      tick();
      ifu_arready = 1'b0; ifu_rvalid = 1'b1; ifu_rdata = 32'h00A0_0513; ifu_rresp = 2'b00;
      settle();
      check("dflush_refetch_stall", IFU_stall, 0);
      tick();
      ifu_rvalid = 1'b0;
      settle();
      check("dflush_refetch_valid", IFU2_valid, 1);
      check("dflush_refetch_pc", IFU2_pc, 32'h8000_0200);
      check("dflush_refetch_inst", IFU2_inst, 32'h00A0_0513);

      // Flush clears a full buffer; a same-cycle handshake is discarded and IDLE holds.
      BRANCH_PCSrc = 1'b1; IFU2_ready = 1'b1;
      settle();
      check("bflush_stall", IFU_stall, 0);
      tick();
      BRANCH_PCSrc = 1'b0; IFU2_ready = 1'b0;
      settle();
      check("bflush_valid", IFU2_valid, 0);
      check("bflush_idle_arvalid", ifu_arvalid, 0);

      // Flush in DATA with rvalid in the same cycle: data discarded, straight back to IDLE.
      tick();
      ifu_arready = 1'b1;
      tick();
      ifu_arready = 1'b0; BRANCH_PCSrc = 1'b1; ifu_rvalid = 1'b1; ifu_rdata = 32'h1111_1111;
      settle();
      check("rflush_stall", IFU_stall, 0);
      tick();
      BRANCH_PCSrc = 1'b0; ifu_rvalid = 1'b0;
      settle();
      check("rflush_valid", IFU2_valid, 0);
      check("rflush_idle_rready", ifu_rready, 0);

      // Asynchronous reset in the middle of ADDR.
      tick();
      settle();
      check("prerst_arvalid", ifu_arvalid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("mrst_arvalid", ifu_arvalid, 0);
      check("mrst_araddr", ifu_araddr, 0);
      check("mrst_valid", IFU2_valid, 0);
      check("mrst_stall", IFU_stall, 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_fetch(vecs[0]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
